// File: rtl/wb_output_bank_if.sv
// ---------------------------------------------------------------------------
// wb_output_bank_if
// Wishbone classic bus bundle between a bus master and wb_output_bank.
//   cyc_i/stb_i/we_i  cycle, strobe, write enable (master -> slave)
//   adr_i             byte address                (master -> slave)
//   sel_i             byte-lane enables           (master -> slave)
//   dat_i             write data / bit mask       (master -> slave)
//   dat_o             registered read data        (slave -> master)
//   ack_o/err_o/rty_o termination signals          (slave -> master)
// ---------------------------------------------------------------------------
interface wb_output_bank_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = 4
) ();
  logic                    cyc_i;
  logic                    stb_i;
  logic                    we_i;
  logic [ADDR_WIDTH-1:0]   adr_i;
  logic [SELECT_WIDTH-1:0] sel_i;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    ack_o;
  logic                    err_o;
  logic                    rty_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, err_o, rty_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/wb_output_bank.sv
// ---------------------------------------------------------------------------
// wb_output_bank
// Wishbone slave holding NUM_REGS output registers that drive GPIO/control
// lines. The address selects a register and a write mode
// (0 overwrite, 1 set, 2 clear, 3 toggle), applied per byte lane under sel_i.
// Transfers terminate with a one-cycle registered ack_o, or err_o when the
// register index is out of range. At most one transfer per two clocks.
//
// Optional feature macro: WB_OUTBANK_PULSE_EN
//   When defined, bits set with mode 1 self-clear PULSE_CYCLES clocks after
//   the commit edge. When undefined, set bits persist.
//
// Ports
//   clock  in   single clock, all state on posedge
//   reset  in   asynchronous active-low reset
//   bus    slave modport of wb_output_bank_if (cyc/stb/we/adr/sel/dat, ack/err/rty)
//   out    out  NUM_REGS*DATA_WIDTH, register i at out[i*DATA_WIDTH +: DATA_WIDTH]
// ---------------------------------------------------------------------------
module wb_output_bank #(
  parameter int                        DATA_WIDTH   = 32,
  parameter int                        SELECT_WIDTH = 4,
  parameter int                        NUM_REGS     = 4,
  parameter int                        IDX_W        = 2,
  parameter int                        ADDR_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]     RESET_PAT    = '0,
  parameter int                        PULSE_CYCLES = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  wb_output_bank_if.slave                bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] out
);

  localparam int GB   = $clog2(SELECT_WIDTH);
  localparam int GRAN = DATA_WIDTH / SELECT_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_ERR} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   dat_o_q, dat_o_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic [1:0]              mode;
  logic [IDX_W-1:0]        idx;
  logic                    idx_ok;
  logic                    req;
  logic                    wr_commit;

  // Expand byte-lane enables into a per-bit mask.
  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [SELECT_WIDTH-1:0] sel);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int l = 0; l < SELECT_WIDTH; l++) begin
      m[l*GRAN +: GRAN] = {GRAN{sel[l]}};
    end
    return m;
  endfunction

  // New register value for a write; unselected lanes keep the old value.
  function automatic logic [DATA_WIDTH-1:0] apply_write(
    input logic [DATA_WIDTH-1:0]   old_v,
    input logic [DATA_WIDTH-1:0]   dat,
    input logic [SELECT_WIDTH-1:0] sel,
    input logic [1:0]              md
  );
    logic [DATA_WIDTH-1:0] m;
    logic [DATA_WIDTH-1:0] nv;
    m = lane_mask(sel);
    case (md)
      2'd0:    nv = dat;
      2'd1:    nv = old_v | dat;
      2'd2:    nv = old_v & ~dat;
      default: nv = old_v ^ dat;
    endcase
    return (nv & m) | (old_v & ~m);
  endfunction

  assign mode      = bus.adr_i[GB+1:GB];
  assign idx       = bus.adr_i[GB+2 +: IDX_W];
  assign idx_ok    = (int'(idx) < NUM_REGS);
  // Requests are only sampled in IDLE, so a strobe held through ACK/ERR
  // cannot commit a second write.
  assign req       = bus.cyc_i & bus.stb_i & (state_q == ST_IDLE);
  assign wr_commit = req & idx_ok & bus.we_i;

  // Unused address bits and the pulse length (ignored in the default build).
  logic unused_ok;
  assign unused_ok = ^{bus.adr_i, (PULSE_CYCLES > 0)};

  // FSM next state
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (req) state_d = idx_ok ? ST_ACK : ST_ERR;
        else     state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: termination decoded from state, never both
  always_comb begin
    bus.ack_o = (state_q == ST_ACK);
    bus.err_o = (state_q == ST_ERR);
    bus.rty_o = 1'b0;
  end

  assign bus.dat_o = dat_o_q;

  // Read data capture
  always_comb begin
    dat_o_d = dat_o_q;
    if (req) begin
      if (!idx_ok)         dat_o_d = '0;
      else if (!bus.we_i)  dat_o_d = regs_q[idx];
    end
  end

`ifdef WB_OUTBANK_PULSE_EN
  localparam int CW = $clog2(PULSE_CYCLES + 1);

  logic [CW-1:0]         cnt_q  [NUM_REGS];
  logic [CW-1:0]         cnt_d  [NUM_REGS];
  logic [DATA_WIDTH-1:0] mask_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mask_d [NUM_REGS];

  // Expiry is applied before a same-edge write so the write wins its bits.
  always_comb begin
    logic [DATA_WIDTH-1:0] base;
    logic [DATA_WIDTH-1:0] wbits;
    base  = '0;
    wbits = bus.dat_i & lane_mask(bus.sel_i);
    for (int i = 0; i < NUM_REGS; i++) begin
      base      = regs_q[i];
      cnt_d[i]  = cnt_q[i];
      mask_d[i] = mask_q[i];
      if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CW'(1);
        if (cnt_q[i] == CW'(1)) begin
          base      = base & ~mask_q[i];
          mask_d[i] = '0;
        end
      end
      regs_d[i] = base;
      if (wr_commit && (int'(idx) == i)) begin
        regs_d[i] = apply_write(base, bus.dat_i, bus.sel_i, mode);
        case (mode)
          2'd0: begin
            cnt_d[i]  = '0;
            mask_d[i] = '0;
          end
          2'd1: begin
            cnt_d[i]  = CW'(PULSE_CYCLES);
            mask_d[i] = mask_d[i] | wbits;
          end
          2'd2:    mask_d[i] = mask_d[i] & ~wbits;
          default: mask_d[i] = mask_d[i];
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i]  <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i]  <= cnt_d[i];
        mask_q[i] <= mask_d[i];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_commit && (int'(idx) == i)) begin
        regs_d[i] = apply_write(regs_q[i], bus.dat_i, bus.sel_i, mode);
      end
    end
  end
`endif

  // State, read data and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dat_o_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_PAT;
    end else begin
      state_q <= state_d;
      dat_o_q <= dat_o_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule
